mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit in the execute stage, beside the ALU. Takes the same
//  in1/in2 operand buses and implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.

---
 rtl/mult_div_unit.sv | 147 ++++++++++++++
 tb/tb_mult_div_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: MULT/MULTU (shift-add) and DIV/DIVU (restoring),
// one iteration per cycle, results written to architectural HI/LO.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      counter;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               dbz;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;

    logic               signed_op;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy      = (state != IDLE);
    assign signed_op = ~op[0];
    assign abs1      = (signed_op && in1[WIDTH-1]) ? -in1 : in1;
    assign abs2      = (signed_op && in2[WIDTH-1]) ? -in2 : in2;

    // Multiply keeps the running product in {acc_hi, acc_lo}; divide keeps the
    // partial remainder in acc_hi and shifts quotient bits into acc_lo.
    assign mul_sum   = {1'b0, acc_hi} + {1'b0, {WIDTH{acc_lo[0]}} & divisor};
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, divisor};

    assign prod_fix  = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quot_fix  = neg_res ? -acc_lo : acc_lo;
    assign rem_fix   = neg_rem ? -acc_hi : acc_hi;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: defaulting state_next first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (counter == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            counter     <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            dbz         <= 1'b0;
            divisor     <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div  <= op[1];
                        neg_res <= signed_op & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                        neg_rem <= signed_op & in1[WIDTH-1];
                        dbz     <= op[1] & (in2 == '0);
                        divisor <= abs2;
                        acc_hi  <= '0;
                        acc_lo  <= abs1;
                        counter <= '0;
                    end else begin
                        if (mthi) hi <= in1;
                        if (mtlo) lo <= in1;
                    end
                end
                RUN: begin
                    counter <= counter + 1'b1;
                    if (is_div) begin
                        if (!div_diff[WIDTH]) begin
                            acc_hi <= div_diff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    // With a zero divisor the remainder path reproduces the dividend.
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= dbz ? '1 : quot_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done        <= 1'b1;
                    div_by_zero <= dbz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// corner sequences, and random operations against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .in1         (in1),
        .in2         (in2),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic        e_z;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic definition of each op.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l, output logic z);
        longint          q;
        longint          r;
        logic [63:0]     p;
        z = 1'b0;
        case (o)
            2'b00: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                h = p[63:32]; l = p[31:0];
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                h = p[63:32]; l = p[31:0];
            end
            2'b10: begin
                if (b == 0) begin
                    h = a; l = '1; z = 1'b1;
                end else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    h = r[31:0]; l = q[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    h = a; l = '1; z = 1'b1;
                end else begin
                    h = a % b; l = a / b;
                end
            end
        endcase
    endtask

    // Launches one op and follows it to done. poke_at>0 drives a second start plus
    // mthi during that busy cycle; with_move raises mthi/mtlo alongside the start.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int poke_at, input logic with_move,
                         output int edges, output int busy_cycles, output int unstable,
                         output logic [31:0] rh, output logic [31:0] rl, output logic rz,
                         output logic done_after);
        logic [31:0] hi0, lo0;
        @(negedge clk);
        hi0 = hi; lo0 = lo;
        start = 1'b1; op = o; in1 = a; in2 = b;
        mthi = with_move; mtlo = with_move;
        edges = 0; busy_cycles = 0; unstable = 0;
        @(posedge clk);
        edges = 1;
        #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        in1 = $urandom; in2 = $urandom; op = 2'($urandom);
        forever begin
            if (busy) busy_cycles++;
            if (done) break;
            if (hi !== hi0 || lo !== lo0) unstable++;
            if (edges >= 100) break;
            if (poke_at > 0 && edges == poke_at) begin
                start = 1'b1; mthi = 1'b1;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            @(posedge clk);
            edges++;
            #1;
        end
        start = 1'b0; mthi = 1'b0;
        rh = hi; rl = lo; rz = div_by_zero;
        @(posedge clk);
        #1;
        done_after = done;
    endtask

    vec_t vecs[10];

    initial begin
        int          edges, bc, unst, dcount;
        logic [31:0] rh, rl, eh, el;
        logic        rz, ez, da;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4] = '{2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
        vecs[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6] = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[7] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[8] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[9] = '{2'b01, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 1'b0};

        reset = 1'b1; start = 1'b0; op = 2'b00; in1 = '0; in2 = '0; mthi = 1'b0; mtlo = 1'b0;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dbz",  64'(div_by_zero), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vector table with latency and pulse-width checks.
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 1'b0, edges, bc, unst, rh, rl, rz, da);
            check($sformatf("vec%0d_hilo", i), {rh, rl}, {vecs[i].e_hi, vecs[i].e_lo});
            check($sformatf("vec%0d_dbz", i), 64'(rz), 64'(vecs[i].e_z));
            check($sformatf("vec%0d_latency", i), 64'(edges), 64'd34);
            check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd33);
            check($sformatf("vec%0d_hilo_stable", i), 64'(unst), 64'd0);
            check($sformatf("vec%0d_done_one_cycle", i), 64'(da), 64'd0);
        end

        // Second start plus mthi mid-op: both ignored, exactly one done.
        do_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 5, 1'b0, edges, bc, unst, rh, rl, rz, da);
        check("poke_result", {rh, rl}, 64'hFFFFFFFF_FFFFFFEB);
        check("poke_latency", 64'(edges), 64'd34);
        check("poke_stable", 64'(unst), 64'd0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("poke_no_second_done", 64'(dcount), 64'd0);
        check("poke_idle", 64'(busy), 64'd0);

        // start and a move in the same idle cycle: start wins.
        do_op(2'b11, 32'd100, 32'd7, 0, 1'b1, edges, bc, unst, rh, rl, rz, da);
        check("start_beats_move_result", {rh, rl}, {32'd2, 32'd14});
        check("start_beats_move_stable", 64'(unst), 64'd0);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        start = 1'b1; op = 2'b01; in1 = 32'hDEADBEEF; in2 = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_busy", 64'(busy), 64'd0);
        check("async_reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) dcount++;
        end
        check("async_reset_no_done", 64'(dcount), 64'd0);

        // MTHI then MTLO in idle.
        @(negedge clk);
        mthi = 1'b1; in1 = 32'hA5A5A5A5;
        @(posedge clk); #1;
        mthi = 1'b0;
        check("mthi_hi", 64'(hi), 64'hA5A5A5A5);
        check("mthi_lo_kept", 64'(lo), 64'd0);
        check("mthi_no_done", 64'(done), 64'd0);
        @(negedge clk);
        mtlo = 1'b1; in1 = 32'h5A5A5A5A;
        @(posedge clk); #1;
        mtlo = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h5A5A5A5A);
        check("mtlo_hi_kept", 64'(hi), 64'hA5A5A5A5);
        check("mtlo_no_done", 64'(done), 64'd0);
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; in1 = 32'h0F0F1234;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        check("mthi_mtlo_both", {hi, lo}, 64'h0F0F1234_0F0F1234);

        // Random operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 15));
                1:       rb = 32'hFFFFFFFF - 32'($urandom_range(0, 15));
                default: rb = $urandom;
            endcase
            model(ro, ra, rb, eh, el, ez);
            do_op(ro, ra, rb, 0, 1'b0, edges, bc, unst, rh, rl, rz, da);
            check($sformatf("rand%0d_op%0d_%h_%h", i, ro, ra, rb), {rh, rl}, {eh, el});
            check($sformatf("rand%0d_dbz", i), 64'(rz), 64'(ez));
            check($sformatf("rand%0d_latency", i), 64'(edges), 64'd34);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
